// File: rtl/psum_feeder_pkg.sv
// Shared definitions for the psum feeder and its neighbours (SFU bank, array FIFO).
// Holds the state encoding, default lane geometry and the lane slice rule.
package psum_feeder_pkg;

  localparam int COL     = 8;
  localparam int PSUM_BW = 16;
  localparam int CNT_BW  = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_STREAM = 3'd1,
    ST_FLUSH  = 3'd2,
    ST_RELU   = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  // Lane i of a packed vector lives at [lane_lo(i, bw) +: bw].
  function automatic int lane_lo(input int lane, input int bw);
    return lane * bw;
  endfunction

endpackage

// File: rtl/psum_feeder.sv
// Streams psum vectors from the array FIFO into the SFU bank for one tile,
// then optionally requests ReLU and pulses done.
module psum_feeder
  import psum_feeder_pkg::*;
#(
  parameter int col     = COL,
  parameter int psum_bw = PSUM_BW,
  parameter int cnt_bw  = CNT_BW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [cnt_bw-1:0]      acc_len,
  input  logic                   relu_en,
  input  logic                   src_valid,
  input  logic [col*psum_bw-1:0] src_data,
  output logic                   src_ready,
  output logic                   sfu_in_valid,
  output logic [col*psum_bw-1:0] sfu_in,
  output logic                   sfu_relu_valid,
  output logic                   busy,
  output logic                   done,
  output logic [cnt_bw-1:0]      acc_cnt
);

  state_e                 state_q, state_d;
  logic [cnt_bw-1:0]      len_q, len_d;
  logic                   relu_q, relu_d;
  logic [cnt_bw-1:0]      cnt_q, cnt_d;
  logic                   vld_q, vld_d;
  logic [col*psum_bw-1:0] data_q, data_d;
  logic                   last_beat;

  assign last_beat = (cnt_q == len_q - cnt_bw'(1));

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    relu_d  = relu_q;
    cnt_d   = cnt_q;
    vld_d   = 1'b0;
    data_d  = data_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d   = acc_len;
          relu_d  = relu_en;
          cnt_d   = '0;
          state_d = (acc_len == '0) ? ST_DONE : ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (src_valid) begin
          data_d = src_data;
          vld_d  = 1'b1;
          cnt_d  = cnt_q + cnt_bw'(1);
          if (last_beat) state_d = ST_FLUSH;
        end
      end
      // Last beat is on the wire; ReLU waits a cycle so it never overlaps in_valid.
      ST_FLUSH: state_d = relu_q ? ST_RELU : ST_DONE;
      ST_RELU:  state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      relu_q  <= 1'b0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      relu_q  <= relu_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      data_q  <= data_d;
    end
  end

  assign src_ready      = (state_q == ST_STREAM);
  assign sfu_relu_valid = (state_q == ST_RELU);
  assign done           = (state_q == ST_DONE);
  assign busy           = (state_q != ST_IDLE);
  assign sfu_in_valid   = vld_q;
  assign sfu_in         = data_q;
  assign acc_cnt        = cnt_q;

endmodule

// File: tb/tb_psum_feeder.sv
// Bench for psum_feeder: scoreboarded beats plus per-scenario handshake,
// ReLU, done and reset checks.
module tb_psum_feeder;
  import psum_feeder_pkg::*;

  localparam int W = COL * PSUM_BW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [7:0]    acc_len = '0;
  logic          relu_en = 1'b0;
  logic          src_valid = 1'b0;
  logic [W-1:0]  src_data = '0;
  logic          src_ready;
  logic          sfu_in_valid;
  logic [W-1:0]  sfu_in;
  logic          sfu_relu_valid;
  logic          busy;
  logic          done;
  logic [7:0]    acc_cnt;

  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  exp_v;
  int pass_cnt = 0;
  int total_cnt = 0;
  int beat_cnt = 0;
  int relu_cnt = 0;
  int lane0_acc = 0;

  psum_feeder dut (
    .clk(clk), .rst(rst), .start(start), .acc_len(acc_len),
    .relu_en(relu_en), .src_valid(src_valid), .src_data(src_data),
    .src_ready(src_ready), .sfu_in_valid(sfu_in_valid), .sfu_in(sfu_in),
    .sfu_relu_valid(sfu_relu_valid), .busy(busy), .done(done),
    .acc_cnt(acc_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Output monitor: pops expected beats and models lane 0 of one SFU.
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      if (sfu_in_valid) begin
        beat_cnt++;
        total_cnt++;
        if (exp_q.size() == 0)
          $display("FAIL sb_unexpected_beat got=%h expected=none", sfu_in);
        else begin
          exp_v = exp_q.pop_front();
          if (sfu_in !== exp_v)
            $display("FAIL sb_beat got=%h expected=%h", sfu_in, exp_v);
          else pass_cnt++;
        end
        lane0_acc += int'(signed'(sfu_in[15:0]));
      end
      if (sfu_relu_valid) begin
        relu_cnt++;
        total_cnt++;
        if (sfu_in_valid)
          $display("FAIL relu_overlap got in_valid=1 expected=0");
        else pass_cnt++;
        if (lane0_acc < 0) lane0_acc = 0;
      end
    end
  end

  function automatic logic [W-1:0] mk(input logic [15:0] l0);
    logic [W-1:0] v;
    v = {$urandom, $urandom, $urandom, $urandom};
    v[15:0] = l0;
    return v;
  endfunction

  task automatic drive_beat(input logic [W-1:0] d);
    src_valid = 1'b1;
    src_data  = d;
    exp_q.push_back(d);
  endtask

  task automatic kick(input logic [7:0] len, input logic relu);
    @(negedge clk);
    start = 1'b1; acc_len = len; relu_en = relu;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    total_cnt++;
    if ({src_ready, sfu_in_valid, sfu_relu_valid, busy, done} !== 5'b0 ||
        acc_cnt !== 8'd0 || sfu_in !== '0)
      $display("FAIL reset_outputs got rdy=%b v=%b rv=%b busy=%b done=%b cnt=%0d",
               src_ready, sfu_in_valid, sfu_relu_valid, busy, done, acc_cnt);
    else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_relu_tile;
    logic [15:0] l0 [3];
    l0 = '{16'd5, 16'hFFFE, 16'd7};
    lane0_acc = 0;
    kick(8'd3, 1'b1);
    total_cnt++;
    if (!(src_ready === 1'b1 && busy === 1'b1 && sfu_in_valid === 1'b0 && acc_cnt === 8'd0))
      $display("FAIL t1_stream_entry got rdy=%b busy=%b v=%b cnt=%0d expected 1 1 0 0",
               src_ready, busy, sfu_in_valid, acc_cnt);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      drive_beat(mk(l0[i]));
      @(negedge clk);
      total_cnt++;
      if (sfu_in_valid !== 1'b1)
        $display("FAIL t1_beat_valid[%0d] got=%b expected=1", i, sfu_in_valid);
      else pass_cnt++;
    end
    src_valid = 1'b0;
    total_cnt++;
    if (src_ready !== 1'b0 || acc_cnt !== 8'd3)
      $display("FAIL t1_flush got rdy=%b cnt=%0d expected 0 3", src_ready, acc_cnt);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (sfu_relu_valid !== 1'b1 || sfu_in_valid !== 1'b0)
      $display("FAIL t1_relu got rv=%b v=%b expected 1 0", sfu_relu_valid, sfu_in_valid);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (done !== 1'b1 || sfu_relu_valid !== 1'b0 || lane0_acc !== 10)
      $display("FAIL t1_done got done=%b rv=%b lane0=%0d expected 1 0 10",
               done, sfu_relu_valid, lane0_acc);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (busy !== 1'b0 || done !== 1'b0 || acc_cnt !== 8'd3)
      $display("FAIL t1_idle got busy=%b done=%b cnt=%0d expected 0 0 3", busy, done, acc_cnt);
    else pass_cnt++;
  endtask

  task automatic test_bubbles;
    logic pat [5];
    int b0;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    b0 = beat_cnt;
    kick(8'd3, 1'b0);
    for (int i = 0; i < 5; i++) begin
      total_cnt++;
      if (src_ready !== 1'b1)
        $display("FAIL t2_ready[%0d] got=%b expected=1", i, src_ready);
      else pass_cnt++;
      if (pat[i]) drive_beat(mk(16'(i)));
      else begin src_valid = 1'b0; src_data = mk(16'hDEAD); end
      @(negedge clk);
      total_cnt++;
      if (sfu_in_valid !== pat[i])
        $display("FAIL t2_valid[%0d] got=%b expected=%b", i, sfu_in_valid, pat[i]);
      else pass_cnt++;
    end
    src_valid = 1'b0;
    total_cnt++;
    if (src_ready !== 1'b0 || beat_cnt - b0 !== 3)
      $display("FAIL t2_flush got rdy=%b beats=%0d expected 0 3", src_ready, beat_cnt - b0);
    else pass_cnt++;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_no_relu;
    int r0;
    r0 = relu_cnt;
    kick(8'd2, 1'b0);
    for (int i = 0; i < 2; i++) begin
      drive_beat(mk(16'(100 + i)));
      @(negedge clk);
    end
    src_valid = 1'b0;
    total_cnt++;
    if (sfu_in_valid !== 1'b1 || src_ready !== 1'b0)
      $display("FAIL t3_flush got v=%b rdy=%b expected 1 0", sfu_in_valid, src_ready);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (done !== 1'b1 || sfu_relu_valid !== 1'b0 || busy !== 1'b1)
      $display("FAIL t3_done got done=%b rv=%b busy=%b expected 1 0 1",
               done, sfu_relu_valid, busy);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (busy !== 1'b0 || relu_cnt !== r0)
      $display("FAIL t3_idle got busy=%b relu_pulses=%0d expected 0 %0d", busy, relu_cnt, r0);
    else pass_cnt++;
  endtask

  task automatic test_zero_len;
    int b0;
    b0 = beat_cnt;
    @(negedge clk);
    start = 1'b1; acc_len = 8'd0; relu_en = 1'b1;
    src_valid = 1'b1; src_data = mk(16'h1234);
    @(negedge clk);
    start = 1'b0;
    total_cnt++;
    if (done !== 1'b1 || src_ready !== 1'b0 || sfu_in_valid !== 1'b0 || acc_cnt !== 8'd0)
      $display("FAIL t4_done got done=%b rdy=%b v=%b cnt=%0d expected 1 0 0 0",
               done, src_ready, sfu_in_valid, acc_cnt);
    else pass_cnt++;
    @(negedge clk);
    src_valid = 1'b0;
    total_cnt++;
    if (busy !== 1'b0 || sfu_relu_valid !== 1'b0 || beat_cnt !== b0)
      $display("FAIL t4_idle got busy=%b rv=%b beats=%0d expected 0 0 %0d",
               busy, sfu_relu_valid, beat_cnt, b0);
    else pass_cnt++;
  endtask

  task automatic test_start_ignored_and_reset;
    kick(8'd4, 1'b0);
    for (int i = 0; i < 2; i++) begin
      drive_beat(mk(16'(200 + i)));
      @(negedge clk);
    end
    drive_beat(mk(16'd202));
    start = 1'b1; acc_len = 8'd1;
    @(negedge clk);
    start = 1'b0;
    total_cnt++;
    if (src_ready !== 1'b1 || acc_cnt !== 8'd3)
      $display("FAIL t5_start_ignored got rdy=%b cnt=%0d expected 1 3", src_ready, acc_cnt);
    else pass_cnt++;
    drive_beat(mk(16'd203));
    @(negedge clk);
    src_valid = 1'b0;
    total_cnt++;
    if (src_ready !== 1'b0 || acc_cnt !== 8'd4)
      $display("FAIL t5_len_kept got rdy=%b cnt=%0d expected 0 4", src_ready, acc_cnt);
    else pass_cnt++;
    repeat (2) @(negedge clk);
    kick(8'd5, 1'b1);
    for (int i = 0; i < 2; i++) begin
      drive_beat(mk(16'(300 + i)));
      @(negedge clk);
    end
    src_valid = 1'b0;
    rst = 1'b1;
    #1;
    total_cnt++;
    if ({src_ready, sfu_in_valid, busy} !== 3'b0 || acc_cnt !== 8'd0 || sfu_in !== '0)
      $display("FAIL t5_async_reset got rdy=%b v=%b busy=%b cnt=%0d expected 0 0 0 0",
               src_ready, sfu_in_valid, busy, acc_cnt);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    kick(8'd1, 1'b0);
    drive_beat(mk(16'd400));
    @(negedge clk);
    src_valid = 1'b0;
    total_cnt++;
    if (sfu_in_valid !== 1'b1 || acc_cnt !== 8'd1 || src_ready !== 1'b0)
      $display("FAIL t5_after_reset got v=%b cnt=%0d rdy=%b expected 1 1 0",
               sfu_in_valid, acc_cnt, src_ready);
    else pass_cnt++;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_lane_order;
    logic [W-1:0] v;
    logic [15:0]  lv;
    for (int i = 0; i < COL; i++) v[lane_lo(i, PSUM_BW) +: PSUM_BW] = 16'h8000 + 16'(i);
    kick(8'd1, 1'b0);
    drive_beat(v);
    @(negedge clk);
    src_valid = 1'b0;
    for (int i = 0; i < COL; i++) begin
      lv = sfu_in[lane_lo(i, PSUM_BW) +: PSUM_BW];
      total_cnt++;
      if (lv !== 16'h8000 + 16'(i))
        $display("FAIL t6_lane[%0d] got=%h expected=%h", i, lv, 16'h8000 + 16'(i));
      else pass_cnt++;
    end
    repeat (2) @(negedge clk);
    total_cnt++;
    if (exp_q.size() != 0 || busy !== 1'b0)
      $display("FAIL sb_drain got pending=%0d busy=%b expected 0 0", exp_q.size(), busy);
    else pass_cnt++;
  endtask

  initial begin
    test_reset;
    test_relu_tile;
    test_bubbles;
    test_no_relu;
    test_zero_len;
    test_start_ignored_and_reset;
    test_lane_order;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
